// File: rtl/priority_encoder_512to9.sv
// Sequential 512-to-9 priority encoder: captures a request vector and drains it one ascending index per valid/ready handshake.
// Define ENC512_COUNT_EN to add the `count` output (indices accepted since the last accepted load).
module priority_encoder_512to9 #(
  parameter int N_IN  = 512,
  parameter int W_OUT = 9,
  parameter int GROUP = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [N_IN-1:0]  in,
  output logic [W_OUT-1:0] out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
`ifdef ENC512_COUNT_EN
  ,
  output logic [W_OUT:0]   count
`endif
);
  localparam int N_GRP = N_IN / GROUP;
  localparam int W_BIT = $clog2(GROUP);
  localparam int W_GRP = W_OUT - W_BIT;
  localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [N_IN-1:0]  pending_reg, pending_next;
  logic [W_OUT-1:0] out_reg, out_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [N_GRP-1:0] grp_any;
  logic [W_BIT-1:0] grp_bit [N_GRP];
  logic [W_GRP-1:0] grp_sel;
  logic [W_OUT-1:0] low_idx;
  logic             slot_free;

  // First level: per-group OR and lowest set bit inside each 64-bit group
  generate
    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
      logic [GROUP-1:0] grp_bits;
      logic [W_BIT-1:0] bit_idx;
      assign grp_bits = pending_reg[gi*GROUP +: GROUP];
      assign grp_any[gi] = |grp_bits;
      always_comb begin
        bit_idx = '0;
        for (int i = GROUP - 1; i >= 0; i--) begin
          if (grp_bits[i]) bit_idx = i[W_BIT-1:0];
        end
      end
      assign grp_bit[gi] = bit_idx;
    end
  endgenerate

  // Second level: lowest non-empty group supplies the upper index bits
  always_comb begin
    grp_sel = '0;
    for (int g = N_GRP - 1; g >= 0; g--) begin
      if (grp_any[g]) grp_sel = g[W_GRP-1:0];
    end
  end

  assign low_idx   = {grp_sel, grp_bit[grp_sel]};
  assign slot_free = !valid_reg || ready;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    out_next     = out_reg;
    valid_next   = valid_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          pending_next = in;
          if (|in) begin
            state_next = SCAN;
            busy_next  = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          if (|pending_reg) begin
            out_next     = low_idx;
            valid_next   = 1'b1;
            pending_next = pending_reg & ~(ONE << low_idx);
          end else begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // done is registered one edge after DONE is entered, giving a single-cycle pulse
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      out_reg     <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else if (en) begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      out_reg     <= out_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign out   = out_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

`ifdef ENC512_COUNT_EN
  localparam logic [W_OUT:0] CNT_ONE = {{W_OUT{1'b0}}, 1'b1};
  logic [W_OUT:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en) begin
      if (state_reg == IDLE && load) begin
        count_reg <= '0;
      end else if (valid_reg && ready) begin
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  assign count = count_reg;
`endif

endmodule

// File: tb/tb_priority_encoder_512to9.sv
// Directed bench for priority_encoder_512to9: a queue of expected ascending indices is checked on every cycle.
module tb_priority_encoder_512to9;
  logic         clk = 1'b0;
  logic         reset, en, load, ready;
  logic [511:0] in_v;
  logic [8:0]   out;
  logic         valid, busy, done;
`ifdef ENC512_COUNT_EN
  logic [9:0]   count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cnt_model = 0;
  bit mon_on = 1'b0;
  bit load_acc = 1'b0;

  always #5 clk = ~clk;

  priority_encoder_512to9 dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (load),
    .in    (in_v),
    .out   (out),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
`ifdef ENC512_COUNT_EN
    ,
    .count (count)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a load for one edge; an accepted load queues its set bits in ascending order
  task automatic ld(input logic [511:0] v, input bit accepted);
    in_v = v;
    load = 1'b1;
    load_acc = accepted;
    if (accepted) begin
      for (int i = 0; i < 512; i++) if (v[i]) exp_q.push_back(i);
    end
    tick();
    load = 1'b0;
    load_acc = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound, input int expected);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk(name, n, expected);
  endtask

  // Scoreboard: whatever is presented while valid must be the head of the expected queue
  always @(negedge clk) begin
    if (mon_on) begin
      if (valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("out_vs_model", int'(out), exp_q[0]);
      end
`ifdef ENC512_COUNT_EN
      chk("count_vs_model", int'(count), cnt_model);
`endif
      if (reset) begin
        exp_q.delete();
        cnt_model = 0;
      end else if (en) begin
        if (load_acc) begin
          cnt_model = 0;
        end else if (valid && ready) begin
          cnt_model++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] vec;
    logic [511:0] other;

    reset = 1'b1; en = 1'b1; load = 1'b0; ready = 1'b1; in_v = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
`ifdef ENC512_COUNT_EN
    chk("rst_count", int'(count), 0);
`endif
    cnt_model = 0;
    mon_on = 1'b1;

    // Single bit 37
    vec = '0; vec[37] = 1'b1;
    ld(vec, 1'b1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_valid0", int'(valid), 0);
    tick();
    chk("t1_out", int'(out), 37);
    chk("t1_valid1", int'(valid), 1);
    tick();
    chk("t1_valid_drop", int'(valid), 0);
    chk("t1_done_early", int'(done), 0);
    chk("t1_busy_drop", int'(busy), 0);
    tick();
    chk("t1_done", int'(done), 1);
    chk("t1_busy_done", int'(busy), 0);
    tick();
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_drained", exp_q.size(), 0);
    $display("TXN single bit 37 checks=%0d", checks);

    // Bits 0, 64, 511
    vec = '0; vec[0] = 1'b1; vec[64] = 1'b1; vec[511] = 1'b1;
    ld(vec, 1'b1);
    tick();
    chk("t2_out0", int'(out), 0);
    tick();
    chk("t2_out64", int'(out), 64);
    tick();
    chk("t2_out511", int'(out), 'h1FF);
    wait_done("t2_done_lat", 10, 2);
    tick();
    chk("t2_done_pulse", int'(done), 0);
    chk("t2_drained", exp_q.size(), 0);
`ifdef ENC512_COUNT_EN
    chk("t2_count", int'(count), 3);
`endif
    $display("TXN bits 0,64,511 checks=%0d", checks);

    // All ones: 512 indices back to back
    vec = '1;
    ld(vec, 1'b1);
    wait_done("t3_done_lat", 600, 514);
    tick();
    chk("t3_done_pulse", int'(done), 0);
    chk("t3_drained", exp_q.size(), 0);
`ifdef ENC512_COUNT_EN
    chk("t3_count", int'(count), 512);
`endif
    $display("TXN all ones checks=%0d", checks);

    // Backpressure on bits 5,6 with an ignored mid-scan load
    vec = '0; vec[5] = 1'b1; vec[6] = 1'b1;
    other = '0; other[100] = 1'b1; other[2] = 1'b1;
    ready = 1'b0;
    ld(vec, 1'b1);
    for (int r = 0; r < 4; r++) begin
      if (r == 2) begin
        in_v = other;
        load = 1'b1;
      end
      tick();
      load = 1'b0;
      chk("t4_hold_out", int'(out), 5);
      chk("t4_hold_valid", int'(valid), 1);
    end
    ready = 1'b1;
    tick();
    chk("t4_out6", int'(out), 6);
    wait_done("t4_done_lat", 10, 2);
    chk("t4_drained", exp_q.size(), 0);
`ifdef ENC512_COUNT_EN
    chk("t4_count", int'(count), 2);
`endif
    tick();
    $display("TXN backpressure bits 5,6 checks=%0d", checks);

    // Zero vector
    ld('0, 1'b1);
    chk("t5_valid", int'(valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done_early", int'(done), 0);
    wait_done("t5_done_lat", 10, 1);
    tick();
    chk("t5_done_pulse", int'(done), 0);
    $display("TXN zero vector checks=%0d", checks);

    // 100-bit scan: freeze with en=0, then abort with reset
    vec = '0;
    for (int i = 0; i < 100; i++) vec[i*5] = 1'b1;
    ld(vec, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_out45", int'(out), 45);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen_out", int'(out), 45);
      chk("t6_frozen_valid", int'(valid), 1);
      chk("t6_frozen_busy", int'(busy), 1);
    end
    en = 1'b1;
    tick();
    chk("t6_resume", int'(out), 50);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_out70", int'(out), 70);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_valid", int'(valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_flushed", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_done", int'(done), 0);
      chk("t6_no_valid", int'(valid), 0);
    end
    $display("TXN reset mid-scan checks=%0d", checks);

    // Scan after abort still works
    vec = '0; vec[3] = 1'b1; vec[300] = 1'b1;
    ld(vec, 1'b1);
    tick();
    chk("t7_out3", int'(out), 3);
    tick();
    chk("t7_out300", int'(out), 300);
    wait_done("t7_done_lat", 10, 2);
    chk("t7_drained", exp_q.size(), 0);
    tick();
    $display("TXN post-reset bits 3,300 checks=%0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_encoder_512to9.md
Name: priority_encoder_512to9

Overview:
- Sequential 512-to-9 encoder: the inverse of the 9-to-512 one-hot decoder.
- Captures a 512-bit request vector and emits the 9-bit index of every set bit, in ascending order, one index per valid/ready handshake.
- Lowest-set-bit search is hierarchical: 8 groups of 64, mirroring the decoder's 3-bit/6-bit split.
- Sits between request/flag vectors and index-consuming logic, e.g. feeding back into the decoder.

Parameters:
- N_IN, 512, request vector width.
- W_OUT, 9, index width; must equal log2(N_IN).
- GROUP, 64, group width for the two-level lowest-bit search.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  global enable; 0 freezes all state and outputs
- load  input  1  request to capture `in`
- in  input  512  request vector
- out  output  9  index of the current set bit
- valid  output  1  `out` holds a valid index
- ready  input  1  consumer accepts `out`
- busy  output  1  scan in progress; `load` is ignored while high
- done  output  1  one-cycle pulse: vector fully drained

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset has priority over `en` and aborts any scan.
  - After reset: state IDLE, pending=0, out=0, valid=0, busy=0, done=0.
- `en`=0: no register changes. Outputs hold, and a handshake (valid&&ready) is not counted.
- All outputs are registered.
- States:
  - IDLE: busy=0, done=0.
    - Edge with en&&load: pending<=in, done<=0.
    - If in!=0, go to SCAN with busy<=1.
    - If in==0, go to DONE.
  - SCAN: busy=1.
    - Each edge where slot is free (!valid, or valid&&ready) and pending!=0: out<=lowest set index of pending, valid<=1, clear that bit in pending.
    - Slot free and pending==0: valid<=0, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE. `load` is ignored in DONE.
- Latency: load sampled at edge k gives the first valid at edge k+1.
- Throughput: with ready held high, one index per cycle. Done asserts the cycle after the final index is accepted.
- Backpressure: while valid&&!ready, out and valid hold and pending is unchanged.
- Lowest-bit search:
  - Group g = lowest of 8 groups with a nonzero OR.
  - Bit b = lowest set bit within that group.
  - Index = {g[2:0], b[5:0]}, i.e. out = g*64 + b.
- Index ordering is strictly ascending. No duplicates. Each set bit is emitted exactly once.
- `load` while busy=1 is ignored; the scan continues unaffected.
- Reset mid-scan: next cycle IDLE, valid=0. Remaining pending bits are discarded and no done pulse is produced.
- Boundary cases:
  - Bit 511 yields out=9'h1FF.
  - Bit 0 yields out=9'h000.
  - All-ones input yields 512 indices, then done.

Optional Feature:
- Macro ENC512_COUNT_EN adds output `count` [9:0].
- `count` = number of indices accepted (valid&&ready&&en) since the last accepted load.
  - Reset value 0; cleared on an accepted load.
  - Holds its final value through DONE and IDLE. Maximum value 512.
- Without the macro: the port and its counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then load in=1<<37, ready=1 -> edge k+1: out=37, valid=1. Next cycle: valid=0. Cycle after: done=1, busy=0.
- in with bits {0,64,511}, ready=1 -> out sequence 0, 64, 511 on consecutive cycles; done pulse once; count=3 with ENC512_COUNT_EN.
- in=all ones, ready=1 -> 512 consecutive indices 0..511; done exactly 1 cycle after index 511 is accepted.
- in bits {5,6}, ready=0 for 4 cycles then 1 -> out=5 held 4 cycles, then 6; load pulsed mid-scan with a different vector is ignored.
- Zero vector load -> no valid; done=1 two edges after the load.
- Reset asserted during a 100-bit scan -> next cycle valid=0, busy=0, no done. Toggling en=0 mid-scan freezes out/pending, and resumes exactly on en=1.
